// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and elaboration checks for the chunked MSB-first magnitude comparator.
package seq_magnitude_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns 1 when the WIDTH/CHUNK pairing cannot be built.
    function automatic bit width_check_fails(input int width, input int chunk);
        if (chunk < 1) return 1'b1;
        if (width < 2) return 1'b1;
        return (width % chunk) != 0;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_cmp.sv
// Combinational CHUNK-bit unsigned comparator built as an MSB-priority chain.
module cmp_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    // The first differing bit from the MSB decides; lower bits are masked once eq drops.
    always_comb begin
        lt = 1'b0;
        gt = 1'b0;
        eq = 1'b1;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (eq) begin
                if (a[i] && !b[i]) begin
                    gt = 1'b1;
                    eq = 1'b0;
                end else if (!a[i] && b[i]) begin
                    lt = 1'b1;
                    eq = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands MSB-first one CHUNK per cycle, exits on the first difference.
module seq_magnitude_comparator
    import seq_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lesser,
    output logic             greater,
    output logic             equal,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (width_check_fails(WIDTH, CHUNK)) begin : g_bad_width
            $error("seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of CHUNK >= 1");
        end
    endgenerate

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [CNT_W-1:0] cnt;
    logic             slice_lt;
    logic             slice_gt;
    logic             slice_eq;
    logic             last_chunk;

    cmp_slice #(.CHUNK(CHUNK)) u_slice (
        .a  (opa[WIDTH-1 -: CHUNK]),
        .b  (opb[WIDTH-1 -: CHUNK]),
        .lt (slice_lt),
        .gt (slice_gt),
        .eq (slice_eq)
    );

    assign last_chunk = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = CMP;
            CMP:     if (!slice_eq || last_chunk) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == CMP) || (state == DONE);
        out_valid = (state == DONE);
    end

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa     <= '0;
            opb     <= '0;
            cnt     <= '0;
            lesser  <= 1'b0;
            greater <= 1'b0;
            equal   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa <= a ^ (signed_mode ? SIGN_MASK : '0);
                        opb <= b ^ (signed_mode ? SIGN_MASK : '0);
                        cnt <= '0;
                    end
                end
                CMP: begin
                    if (!slice_eq) begin
                        lesser  <= slice_lt;
                        greater <= slice_gt;
                    end else if (last_chunk) begin
                        equal <= 1'b1;
                    end else begin
                        opa <= opa << CHUNK;
                        opb <= opb << CHUNK;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        lesser  <= 1'b0;
                        greater <= 1'b0;
                        equal   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands. Works MSB-first, one CHUNK-bit slice per cycle, and stops early at the first slice that differs. Supports unsigned and two's-complement signed modes. Operands enter on a valid/ready handshake and results leave on a second valid/ready handshake. Intended for datapaths where a full-width flat comparator is too deep for timing.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of CHUNK; minimum 2.
CHUNK, 4, bits compared per cycle; minimum 1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands and mode are presented this cycle.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  WIDTH  first operand.
b  input  WIDTH  second operand.
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned compare.
out_valid  output  1  result flags are valid.
out_ready  input  1  consumer takes the result.
lesser  output  1  a < b.
greater  output  1  a > b.
equal  output  1  a == b.
busy  output  1  high in CMP and DONE states.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - out_valid, lesser, greater, equal and busy are all 0.
  - in_ready reads 1, since it decodes combinationally from IDLE.
  - Operand registers clear to 0.
  - Reset mid-operation abandons the operation with no result produced.
- NCHUNK = WIDTH/CHUNK.
- Signed handling: when signed_mode=1, the MSB of both a and b is inverted at capture. The rest of the compare is then purely unsigned.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture a, b (sign-adjusted) into shift registers, clear the chunk counter, go to CMP.
- State CMP:
  - Each cycle the top CHUNK bits of both registers are compared by the slice sub-module.
  - Slices differ: register lesser/greater from the slice result (equal=0), set out_valid, go to DONE.
  - Slices equal and counter == NCHUNK-1: register equal=1, set out_valid, go to DONE.
  - Otherwise: shift both registers left by CHUNK, increment the counter, stay in CMP.
  - in_valid is ignored here and in DONE; no operands are lost because in_ready=0.
- State DONE:
  - out_valid=1; lesser/greater/equal are held stable while out_ready=0.
  - On an edge with out_ready=1: clear out_valid and all three flags, go to IDLE.
  - A new accept is possible on the following edge; the minimum issue interval is 1 + k + 1 edges.
- Latency: with the accept edge as E0, out_valid is high after edge E0+k.
  - k = 1-based index, from the MSB, of the first differing chunk.
  - k = NCHUNK when the operands are equal.
  - Minimum latency is 1 edge; maximum is NCHUNK edges.
- Invariant: when out_valid=1, exactly one of lesser/greater/equal is 1. When out_valid=0, all three are 0.
- CHUNK == WIDTH is legal: single-cycle CMP, and every result arrives after edge E0+1.
- Chunk counter width is max(1, clog2(NCHUNK)). The counter never wraps, because CMP always exits at NCHUNK-1.

Decomposition:
- Shared package:
  - State enum {IDLE, CMP, DONE}.
  - A width-check function that flags WIDTH % CHUNK != 0; instantiation fails elaboration when the check flags.
- Sub-module cmp_slice (parameter CHUNK):
  - Purely combinational CHUNK-bit comparator.
  - Outputs lt, gt and eq, computed with the MSB-priority equal/less/greater chain generalised to CHUNK bits.
  - Instantiated once in the top.

Test Plan:
(WIDTH=16, CHUNK=4, so NCHUNK=4; out_ready=1 unless stated.)
1. Equal operands: a=0x1234, b=0x1234, unsigned → equal=1, lesser=0, greater=0; out_valid high after E0+4; in_ready back to 1 one edge later.
2. Top slice differs: a=0x8000, b=0x7FFF. Unsigned → greater=1 after E0+1. Same operands with signed_mode=1 → lesser=1 after E0+1.
3. Last slice differs: a=0x1235, b=0x1234 → greater=1 after E0+4. Then a=0xFFF0, b=0xFFF1, signed → lesser=1 after E0+4.
4. Backpressure: a=0x0001, b=0x0002 with out_ready=0 for 5 cycles → lesser=1 and out_valid held stable, in_ready=0, and a competing in_valid is ignored. With out_ready=1 → IDLE; the next operands are accepted and give the correct result.
5. Reset mid-CMP: assert rst_n low 2 cycles after accept → out_valid, lesser, greater, equal and busy go to 0 immediately, without waiting for a clock edge. After release, in_ready=1 and a fresh compare a=0x0000, b=0x0000 gives equal=1 after E0+4.
6. Sweep with random signed/unsigned pairs plus corners 0x0000/0xFFFF/0x7FFF/0x8000 → flags match a reference model; exactly one flag set per result; latency equals the first-differing-chunk index.
